// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with registered ID/EX output, operand forwarding
// from NUM_FWD later stages, load-use stall and synchronous flush.
//
// state         | meaning
// out_valid = 0 | ID/EX register empty (or bubble), can accept an instruction
// out_valid = 1 | ID/EX register holds an instruction until EX takes it
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           pc_i,
  input  logic [31:0]                 inst_i,
  output logic                        reg1_re_o,
  output logic                        reg2_re_o,
  output logic [REG_AW-1:0]           reg1_addr_o,
  output logic [REG_AW-1:0]           reg2_addr_o,
  input  logic [DATA_W-1:0]           reg1_data_i,
  input  logic [DATA_W-1:0]           reg2_data_i,
  input  logic [NUM_FWD-1:0]          fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]          fwd_is_load,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           pc_o,
  output logic [ALUOP_W-1:0]          aluop_o,
  output logic [ALUSEL_W-1:0]         alusel_o,
  output logic [DATA_W-1:0]           reg1_o,
  output logic [DATA_W-1:0]           reg2_o,
  output logic [REG_AW-1:0]           waddr_o,
  output logic                        we_o,
  output logic                        inst_invalid_o
);

  // Major opcodes and SPECIAL function codes
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] FN_SLL      = 6'b000000;
  localparam logic [5:0] FN_SRL      = 6'b000010;
  localparam logic [5:0] FN_SRA      = 6'b000011;
  localparam logic [5:0] FN_AND      = 6'b100100;
  localparam logic [5:0] FN_OR       = 6'b100101;
  localparam logic [5:0] FN_XOR      = 6'b100110;
  localparam logic [5:0] FN_NOR      = 6'b100111;

  // ALU sub-op and result-class codes (same values as defines.v)
  localparam logic [ALUOP_W-1:0]  EXE_OP_NOP    = ALUOP_W'(8'b0000_0000);
  localparam logic [ALUOP_W-1:0]  EXE_OP_AND    = ALUOP_W'(8'b0010_0100);
  localparam logic [ALUOP_W-1:0]  EXE_OP_OR     = ALUOP_W'(8'b0010_0101);
  localparam logic [ALUOP_W-1:0]  EXE_OP_XOR    = ALUOP_W'(8'b0010_0110);
  localparam logic [ALUOP_W-1:0]  EXE_OP_NOR    = ALUOP_W'(8'b0010_0111);
  localparam logic [ALUOP_W-1:0]  EXE_OP_SLL    = ALUOP_W'(8'b0111_1100);
  localparam logic [ALUOP_W-1:0]  EXE_OP_SRL    = ALUOP_W'(8'b0000_0010);
  localparam logic [ALUOP_W-1:0]  EXE_OP_SRA    = ALUOP_W'(8'b0000_0011);
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = ALUSEL_W'(3'b000);
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = ALUSEL_W'(3'b010);

  logic [5:0]  opc, fn;
  logic [4:0]  f_rs, f_rt, f_rd, f_sa;
  logic [15:0] imm16;

  assign opc   = inst_i[31:26];
  assign f_rs  = inst_i[25:21];
  assign f_rt  = inst_i[20:16];
  assign f_rd  = inst_i[15:11];
  assign f_sa  = inst_i[10:6];
  assign fn    = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  logic [ALUOP_W-1:0]  d_aluop;
  logic [ALUSEL_W-1:0] d_alusel;
  logic [REG_AW-1:0]   d_waddr;
  logic                d_we, d_inv, use1, use2;
  logic [DATA_W-1:0]   imm1, imm2;

  // Instruction decode: control fields, which ports read, immediate operands
  always_comb begin
    d_aluop  = EXE_OP_NOP;
    d_alusel = EXE_RES_NOP;
    d_waddr  = '0;
    d_we     = 1'b0;
    d_inv    = 1'b1;
    use1     = 1'b0;
    use2     = 1'b0;
    imm1     = '0;
    imm2     = '0;
    case (opc)
      OPC_ORI, OPC_ANDI, OPC_XORI: begin
        d_aluop  = (opc == OPC_ORI)  ? EXE_OP_OR  :
                   (opc == OPC_ANDI) ? EXE_OP_AND : EXE_OP_XOR;
        d_alusel = EXE_RES_LOGIC;
        d_waddr  = REG_AW'(f_rt);
        d_we     = 1'b1;
        d_inv    = 1'b0;
        use1     = 1'b1;
        imm2     = DATA_W'(imm16);
      end
      OPC_LUI: begin
        // LUI executes as OR of (imm<<16) with zero
        d_aluop  = EXE_OP_OR;
        d_alusel = EXE_RES_LOGIC;
        d_waddr  = REG_AW'(f_rt);
        d_we     = 1'b1;
        d_inv    = 1'b0;
        imm1     = DATA_W'({imm16, 16'h0000});
      end
      OPC_SPECIAL: begin
        if (inst_i == 32'h0000_0000) begin
          d_inv = 1'b0;
        end else begin
          case (fn)
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              if (f_sa == 5'd0) begin
                d_aluop  = (fn == FN_AND) ? EXE_OP_AND :
                           (fn == FN_OR)  ? EXE_OP_OR  :
                           (fn == FN_XOR) ? EXE_OP_XOR : EXE_OP_NOR;
                d_alusel = EXE_RES_LOGIC;
                d_waddr  = REG_AW'(f_rd);
                d_we     = 1'b1;
                d_inv    = 1'b0;
                use1     = 1'b1;
                use2     = 1'b1;
              end
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              if (f_rs == 5'd0) begin
                d_aluop  = (fn == FN_SLL) ? EXE_OP_SLL :
                           (fn == FN_SRL) ? EXE_OP_SRL : EXE_OP_SRA;
                d_alusel = EXE_RES_SHIFT;
                d_waddr  = REG_AW'(f_rd);
                d_we     = 1'b1;
                d_inv    = 1'b0;
                use2     = 1'b1;
                imm1     = DATA_W'(f_sa);
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign reg1_addr_o = REG_AW'(f_rs);
  assign reg2_addr_o = REG_AW'(f_rt);
  assign reg1_re_o   = in_valid && use1;
  assign reg2_re_o   = in_valid && use2;

  logic [DATA_W-1:0] op1, op2;
  logic              busy1, busy2;

  // Operand resolution; descending scan so the youngest matching source wins
  always_comb begin
    op1   = reg1_data_i;
    op2   = reg2_data_i;
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_waddr[k*REG_AW +: REG_AW] == reg1_addr_o)) begin
        op1   = fwd_wdata[k*DATA_W +: DATA_W];
        busy1 = fwd_is_load[k];
      end
      if (fwd_we[k] && (fwd_waddr[k*REG_AW +: REG_AW] == reg2_addr_o)) begin
        op2   = fwd_wdata[k*DATA_W +: DATA_W];
        busy2 = fwd_is_load[k];
      end
    end
    if (reg1_addr_o == '0) begin
      op1   = '0;
      busy1 = 1'b0;
    end
    if (reg2_addr_o == '0) begin
      op2   = '0;
      busy2 = 1'b0;
    end
    if (!use1) begin
      op1   = imm1;
      busy1 = 1'b0;
    end
    if (!use2) begin
      op2   = imm2;
      busy2 = 1'b0;
    end
  end

  logic stall, advance, load_en;

  assign stall    = in_valid && (busy1 || busy2);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !stall && !flush;
  assign load_en  = in_valid && in_ready;

  // ID/EX register: valid flag follows handshake; payload only on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      pc_o           <= '0;
      aluop_o        <= EXE_OP_NOP;
      alusel_o       <= EXE_RES_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      waddr_o        <= '0;
      we_o           <= 1'b0;
      inst_invalid_o <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= load_en;
      end
      if (load_en) begin
        pc_o           <= pc_i;
        aluop_o        <= d_aluop;
        alusel_o       <= d_alusel;
        reg1_o         <= op1;
        reg2_o         <= op2;
        waddr_o        <= d_waddr;
        we_o           <= d_we;
        inst_invalid_o <= d_inv;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus a randomized
// stream compared against a behavioural model of the decode stage.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc_i, inst_i;
  logic        reg1_re_o, reg2_re_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_we, fwd_is_load;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        flush, out_valid, out_ready;
  logic [31:0] pc_o, reg1_o, reg2_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [4:0]  waddr_o;
  logic        we_o, inst_invalid_o;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26,
                         OP_NOR = 8'h27, OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [2:0] RES_NOP = 3'd0, RES_LOGIC = 3'd1, RES_SHIFT = 3'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  waddr;
    logic        we;
    logic        inv;
  } pay_t;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_is_load(fwd_is_load), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .waddr_o(waddr_o),
    .we_o(we_o), .inst_invalid_o(inst_invalid_o)
  );

  always #5 clk = ~clk;

  // Value a register read sees: $0, else youngest matching producer, else regfile
  function automatic void resolve(input logic [4:0] a, input logic [31:0] rf,
                                  output logic [31:0] v, output logic busy);
    v = rf;
    busy = 1'b0;
    if (a == 5'd0) begin
      v = 32'd0;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (fwd_we[k] && fwd_waddr[k*5 +: 5] == a) begin
        v = fwd_wdata[k*32 +: 32];
        busy = fwd_is_load[k];
        return;
      end
    end
  endfunction

  // Architectural meaning of one instruction word
  function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                output pay_t p, output logic u1, output logic u2,
                                output logic b1, output logic b2);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [31:0] v1, v2;
    op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16];
    rd = inst[15:11]; sa = inst[10:6]; fn = inst[5:0]; imm = inst[15:0];
    resolve(rs, reg1_data_i, v1, b1);
    resolve(rt, reg2_data_i, v2, b2);
    p = '0;
    p.pc = pc;
    p.inv = 1'b1;
    u1 = 1'b0;
    u2 = 1'b0;
    if (op == 6'h0d || op == 6'h0c || op == 6'h0e) begin
      p.aluop = (op == 6'h0d) ? OP_OR : (op == 6'h0c) ? OP_AND : OP_XOR;
      p.alusel = RES_LOGIC; p.waddr = rt; p.we = 1; p.inv = 0;
      u1 = 1; p.r1 = v1; p.r2 = {16'h0, imm};
    end else if (op == 6'h0f) begin
      p.aluop = OP_OR; p.alusel = RES_LOGIC; p.waddr = rt; p.we = 1; p.inv = 0;
      p.r1 = {imm, 16'h0}; p.r2 = 0;
    end else if (inst == 32'h0) begin
      p.inv = 0;
    end else if (op == 6'h00 && fn[5:2] == 4'b1001 && sa == 0) begin
      p.aluop = (fn == 6'h24) ? OP_AND : (fn == 6'h25) ? OP_OR : (fn == 6'h26) ? OP_XOR : OP_NOR;
      p.alusel = RES_LOGIC; p.waddr = rd; p.we = 1; p.inv = 0;
      u1 = 1; u2 = 1; p.r1 = v1; p.r2 = v2;
    end else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) && rs == 0) begin
      p.aluop = (fn == 6'h00) ? OP_SLL : (fn == 6'h02) ? OP_SRL : OP_SRA;
      p.alusel = RES_SHIFT; p.waddr = rd; p.we = 1; p.inv = 0;
      u2 = 1; p.r1 = {27'h0, sa}; p.r2 = v2;
    end
    if (!u1) b1 = 1'b0;
    if (!u2) b2 = 1'b0;
  endfunction

  task automatic drive_idle();
    in_valid = 0; pc_i = 0; inst_i = 0; reg1_data_i = 0; reg2_data_i = 0;
    fwd_we = 0; fwd_waddr = 0; fwd_wdata = 0; fwd_is_load = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    drive_idle();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if ({pc_o, reg1_o, reg2_o} !== 96'd0) begin errors++; $display("FAIL reset_data got=%h %h %h exp=0", pc_o, reg1_o, reg2_o); end
    checks++; if ({aluop_o, alusel_o, waddr_o, we_o, inst_invalid_o} !== 18'd0) begin
      errors++; $display("FAIL reset_ctrl got=%h %h %h %b %b exp=0", aluop_o, alusel_o, waddr_o, we_o, inst_invalid_o); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_ori();
    @(negedge clk);
    drive_idle(); in_valid = 1; pc_i = 32'h100; inst_i = 32'h3401_1100;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ori_in_ready got=%b exp=1", in_ready); end
    checks++; if (reg1_re_o !== 1'b1 || reg2_re_o !== 1'b0 || reg1_addr_o !== 5'd0) begin
      errors++; $display("FAIL ori_re got=%b%b a=%0d exp=10 a=0", reg1_re_o, reg2_re_o, reg1_addr_o); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || reg1_o !== 0 || reg2_o !== 32'h1100 || waddr_o !== 1 || we_o !== 1
                  || alusel_o !== RES_LOGIC || aluop_o !== OP_OR || pc_o !== 32'h100) begin
      errors++; $display("FAIL ori_out got=v%b %h %h w%0d we%b sel%0d op%h exp=v1 0 1100 w1 we1 sel1 op25",
                         out_valid, reg1_o, reg2_o, waddr_o, we_o, alusel_o, aluop_o); end
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    drive_idle(); in_valid = 1; inst_i = 32'h0022_1825;
    fwd_we = 2'b11; fwd_waddr = {5'd1, 5'd1}; fwd_wdata = {32'h5, 32'hAAAA_0000};
    reg1_data_i = 32'hDEAD_BEEF; reg2_data_i = 32'h0F;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || reg1_o !== 32'hAAAA_0000 || reg2_o !== 32'h0F || waddr_o !== 3) begin
      errors++; $display("FAIL fwd_priority got=v%b %h %h w%0d exp=v1 aaaa0000 f w3", out_valid, reg1_o, reg2_o, waddr_o); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_idle(); in_valid = 1; inst_i = 32'h0042_2024;
    fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd2}; fwd_is_load = 2'b01;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL loaduse_stall_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL loaduse_bubble got=%b exp=0", out_valid); end
    @(negedge clk);
    fwd_is_load = 2'b00; fwd_wdata = {32'h0, 32'h7};
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_release got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || reg1_o !== 7 || reg2_o !== 7 || aluop_o !== OP_AND) begin
      errors++; $display("FAIL loaduse_out got=v%b %h %h op%h exp=v1 7 7 op24", out_valid, reg1_o, reg2_o, aluop_o); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive_idle(); in_valid = 1; inst_i = 32'h3C05_1234;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || reg1_o !== 32'h1234_0000 || reg2_o !== 0) begin
      errors++; $display("FAIL lui_out got=v%b %h %h exp=v1 12340000 0", out_valid, reg1_o, reg2_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 0; inst_i = 32'h3406_0055;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1 || reg1_o !== 32'h1234_0000 || waddr_o !== 5) begin
        errors++; $display("FAIL bp_hold[%0d] got=v%b %h w%0d exp=v1 12340000 w5", i, out_valid, reg1_o, waddr_o); end
    end
    @(negedge clk);
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || reg1_o !== 0 || reg2_o !== 32'h55 || waddr_o !== 6) begin
      errors++; $display("FAIL bp_next got=v%b %h %h w%0d exp=v1 0 55 w6", out_valid, reg1_o, reg2_o, waddr_o); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive_idle(); out_ready = 0; flush = 1; in_valid = 1; inst_i = 32'h3407_0001;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_invalid();
    @(negedge clk);
    drive_idle(); in_valid = 1; inst_i = 32'hFC00_0000;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || inst_invalid_o !== 1 || we_o !== 0 || aluop_o !== OP_NOP) begin
      errors++; $display("FAIL invalid got=v%b inv%b we%b op%h exp=v1 inv1 we0 op00", out_valid, inst_invalid_o, we_o, aluop_o); end
    @(negedge clk);
    inst_i = 32'h0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || inst_invalid_o !== 0 || we_o !== 0) begin
      errors++; $display("FAIL nop got=v%b inv%b we%b exp=v1 inv0 we0", out_valid, inst_invalid_o, we_o); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive_idle(); in_valid = 1; pc_i = 32'h40; inst_i = 32'h3401_00FF;
    @(posedge clk); #2;
    rst = 0;
    #1;
    checks++; if (out_valid !== 0 || reg2_o !== 0 || we_o !== 0 || pc_o !== 0 || waddr_o !== 0) begin
      errors++; $display("FAIL async_reset got=v%b %h we%b pc%h w%0d exp=all 0", out_valid, reg2_o, we_o, pc_o, waddr_o); end
    @(negedge clk);
    rst = 1; pc_i = 32'h44; inst_i = 32'h3402_0033;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1 || reg2_o !== 32'h33 || waddr_o !== 2 || pc_o !== 32'h44) begin
      errors++; $display("FAIL post_reset got=v%b %h w%0d pc%h exp=v1 33 w2 pc44", out_valid, reg2_o, waddr_o, pc_o); end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd, sa;
    logic [15:0] imm;
    int kind;
    logic [5:0] fns[4];
    fns = '{6'h24, 6'h25, 6'h26, 6'h27};
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
    sa = 5'($urandom); imm = 16'($urandom);
    kind = $urandom_range(0, 10);
    case (kind)
      0: return {6'h0d, rs, rt, imm};
      1: return {6'h0c, rs, rt, imm};
      2: return {6'h0e, rs, rt, imm};
      3: return {6'h0f, 5'd0, rt, imm};
      4, 5, 6: return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 3)]};
      7: return {6'h00, 5'd0, rt, rd, sa, 6'h00};
      8: return {6'h00, 5'd0, rt, rd, sa, ($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03};
      9: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    pay_t nxt, exp_p;
    logic u1, u2, b1, b2, mstall, adv, exp_v;
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain got=%b exp=0", out_valid); end
    exp_v = 0;
    exp_p = '0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 8);
      pc_i = $urandom; inst_i = rand_inst();
      reg1_data_i = $urandom; reg2_data_i = $urandom;
      fwd_we = 2'($urandom);
      fwd_waddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_wdata = {32'($urandom), 32'($urandom)};
      fwd_is_load = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      flush = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      model(inst_i, pc_i, nxt, u1, u2, b1, b2);
      mstall = in_valid && (b1 || b2);
      adv = !exp_v || out_ready;
      checks++; if (in_ready !== (adv && !mstall && !flush)) begin
        errors++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b inst=%h", c, in_ready, adv && !mstall && !flush, inst_i); end
      checks++; if ({reg1_re_o, reg2_re_o, reg1_addr_o, reg2_addr_o} !== {in_valid && u1, in_valid && u2, inst_i[25:21], inst_i[20:16]}) begin
        errors++; $display("FAIL rand_read[%0d] got=%b%b %0d %0d exp=%b%b %0d %0d", c, reg1_re_o, reg2_re_o,
                           reg1_addr_o, reg2_addr_o, in_valid && u1, in_valid && u2, inst_i[25:21], inst_i[20:16]); end
      if (flush) exp_v = 0;
      else if (adv) begin
        exp_v = in_valid && !mstall;
        if (exp_v) exp_p = nxt;
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if ({pc_o, aluop_o, alusel_o, reg1_o, reg2_o, waddr_o, we_o, inst_invalid_o} !== exp_p) begin
          errors++;
          $display("FAIL rand_payload[%0d] got=%h %h %h %h %h %h %b %b exp=%h %h %h %h %h %h %b %b", c,
                   pc_o, aluop_o, alusel_o, reg1_o, reg2_o, waddr_o, we_o, inst_invalid_o,
                   exp_p.pc, exp_p.aluop, exp_p.alusel, exp_p.r1, exp_p.r2, exp_p.waddr, exp_p.we, exp_p.inv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ori();
    test_fwd_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_invalid();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
